// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS control FSM driving ALU code, operand muxes and datapath enables,
// with a bounded req/ready wait on memory in FETCH, MEMRD and MEMWR.
module multicycle_control #(
   parameter int FETCH_WAIT_MAX = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic [3:0] alu_ctrl,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_src,
   output logic       pc_en,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       illegal_instr,
   output logic       mem_timeout
);
   localparam int WW = $clog2(FETCH_WAIT_MAX + 1);
   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_ALUWB, S_MEMADR, S_MEMRD,
      S_MEMWB, S_MEMWR, S_BRANCH, S_ADDI_EX, S_ADDI_WB, S_JUMP
   } state_t;
   state_t r_state, w_next;
   logic [WW-1:0] r_wait;
   logic w_waiting, w_timeout, w_op_ok, w_funct_ok;
   logic [3:0] w_alu_r;
   assign w_waiting   = r_state inside {S_FETCH, S_MEMRD, S_MEMWR};
   assign w_timeout   = w_waiting && !mem_ready && r_wait == WW'(FETCH_WAIT_MAX - 1);
   assign mem_timeout = w_timeout;
   assign w_op_ok     = opcode inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
   assign w_funct_ok  = funct inside {6'h24, 6'h25, 6'h20, 6'h22, 6'h2A, 6'h27, 6'h00};
   always_comb
      w_alu_r = funct == 6'h25 ? 4'd1 :
                funct == 6'h20 ? 4'd2 :
                funct == 6'h22 ? 4'd6 :
                funct == 6'h2A ? 4'd7 :
                funct == 6'h27 ? 4'd12 :
                funct == 6'h00 ? 4'd13 : 4'd0;
   always_ff @(posedge clk or posedge reset)
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   // Any state change or timeout restart counts as entry; the counter only advances while stalled.
   always_ff @(posedge clk or posedge reset)
      if (reset)                                    r_wait <= '0;
      else if (w_next != r_state || w_timeout)      r_wait <= '0;
      else if (w_waiting && !mem_ready && r_wait != WW'(FETCH_WAIT_MAX))
                                                    r_wait <= r_wait + WW'(1);
   always_comb begin
      w_next = S_IDLE;
      case (r_state)
         S_IDLE:    w_next = S_FETCH;
         S_FETCH:   w_next = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE:  w_next = opcode == 6'h00 ? S_EXEC_R :
                             (opcode == 6'h23 || opcode == 6'h2B) ? S_MEMADR :
                             opcode == 6'h04 ? S_BRANCH :
                             opcode == 6'h08 ? S_ADDI_EX :
                             opcode == 6'h02 ? S_JUMP : S_FETCH;
         S_EXEC_R:  w_next = w_funct_ok ? S_ALUWB : S_FETCH;
         S_MEMADR:  w_next = opcode == 6'h23 ? S_MEMRD : S_MEMWR;
         S_MEMRD:   w_next = mem_ready ? S_MEMWB : w_timeout ? S_FETCH : S_MEMRD;
         S_MEMWR:   w_next = (mem_ready || w_timeout) ? S_FETCH : S_MEMWR;
         S_ADDI_EX: w_next = S_ADDI_WB;
         S_ALUWB, S_MEMWB, S_BRANCH, S_ADDI_WB, S_JUMP: w_next = S_FETCH;
         default:   w_next = S_IDLE;
      endcase
   end
   always_comb begin
      alu_ctrl      = 4'd0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'd0;
      pc_src        = 2'd0;
      pc_en         = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      illegal_instr = 1'b0;
      case (r_state)
         S_FETCH:   begin mem_read = 1'b1; alu_src_b = 2'd1; alu_ctrl = 4'd2; ir_write = mem_ready; pc_en = mem_ready; end
         S_DECODE:  begin alu_src_b = 2'd3; alu_ctrl = 4'd2; illegal_instr = !w_op_ok; end
         S_EXEC_R:  begin alu_src_a = 1'b1; alu_ctrl = w_alu_r; illegal_instr = !w_funct_ok; end
         S_ALUWB:   begin reg_write = 1'b1; reg_dst = 1'b1; end
         S_MEMADR:  begin alu_src_a = 1'b1; alu_src_b = 2'd2; alu_ctrl = 4'd2; end
         S_MEMRD:   begin mem_read = 1'b1; iord = 1'b1; end
         S_MEMWB:   begin reg_write = 1'b1; mem_to_reg = 1'b1; end
         S_MEMWR:   begin mem_write = 1'b1; iord = 1'b1; end
         S_BRANCH:  begin alu_src_a = 1'b1; alu_ctrl = 4'd6; pc_src = 2'd1; pc_en = zero; end
         S_ADDI_EX: begin alu_src_a = 1'b1; alu_src_b = 2'd2; alu_ctrl = 4'd2; end
         S_ADDI_WB: reg_write = 1'b1;
         S_JUMP:    begin pc_src = 2'd2; pc_en = 1'b1; end
         default:   ;
      endcase
   end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: builds per-instruction expected cycle traces from the instruction's phases
// (fetch wait, decode, execute, memory wait, writeback) and compares every cycle of the control outputs.
module tb_multicycle_control;
   logic clk = 1'b0, reset = 1'b1, zero = 1'b0, mem_ready = 1'b0;
   logic [5:0] opcode = '0, funct = '0;
   logic [3:0] alu_ctrl;
   logic [1:0] alu_src_b, pc_src;
   logic alu_src_a, pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, illegal_instr, mem_timeout;
   logic [18:0] got;
   int compared = 0, errs = 0;
   multicycle_control #(.FETCH_WAIT_MAX(16)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .alu_ctrl(alu_ctrl), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src), .pc_en(pc_en),
      .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write), .illegal_instr(illegal_instr), .mem_timeout(mem_timeout));
   always #5 clk = ~clk;
   assign got = {alu_ctrl, alu_src_a, alu_src_b, pc_src, pc_en, iord, mem_read, mem_write, ir_write,
                 reg_dst, mem_to_reg, reg_write, illegal_instr, mem_timeout};
   localparam logic [18:0] PE = 19'h200, IORD = 19'h100, MR = 19'h080, MW = 19'h040, IRW = 19'h020,
                           RD = 19'h010, M2R = 19'h008, RW = 19'h004, ILL = 19'h002, TO = 19'h001;
   logic [5:0] fn_tab [7] = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h2A, 6'h27, 6'h00};
   int alu_tab [7] = '{0, 1, 2, 6, 7, 12, 13};
   typedef struct { logic rdy; logic z; logic [18:0] exp; string tag; } rec_t;
   rec_t q[$];
   function automatic logic [18:0] o(input int alu, input int a, input int b, input int pcs);
      return {alu[3:0], a[0], b[1:0], pcs[1:0], 10'b0};
   endfunction
   task automatic check(input string t, input logic [18:0] e);
      compared++;
      assert (got === e) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", t, got, e);
      end
   endtask
   task automatic push(input logic rdy, input logic z, input logic [18:0] e, input string t);
      rec_t r;
      r.rdy = rdy; r.z = z; r.exp = e; r.tag = t;
      q.push_back(r);
   endtask
   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction
   // A memory-wait phase: w stalled cycles then one ready cycle, or a timeout on the 16th stalled cycle.
   task automatic wait_phase(input logic [18:0] busy, input logic [18:0] ready, input int w, input string t, output bit ab);
      ab = 0;
      for (int i = 0; i < w; i++) begin
         if (i == 15) begin
            push(1'b0, rb(), busy | TO, {t, "_timeout"});
            ab = 1;
            return;
         end
         push(1'b0, rb(), busy, t);
      end
      push(1'b1, rb(), ready, t);
   endtask
   task automatic run_q(input int n);
      rec_t r;
      int c = 0;
      while (q.size() > 0 && c < n) begin
         r = q.pop_front();
         mem_ready = r.rdy;
         zero = r.z;
         #1 check(r.tag, r.exp);
         @(negedge clk);
         c++;
      end
      q.delete();
   endtask
   task automatic ins(input logic [5:0] op, input logic [5:0] fn, input int wf, input int wm, input int zb);
      bit ab;
      int alu;
      logic z;
      opcode = op;
      funct = fn;
      wait_phase(o(2, 0, 1, 0) | MR, o(2, 0, 1, 0) | MR | IRW | PE, wf, "fetch", ab);
      if (!ab) begin
         if (!(op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02})) push(rb(), rb(), o(2, 0, 3, 0) | ILL, "decode_illegal");
         else push(rb(), rb(), o(2, 0, 3, 0), "decode");
         case (op)
            6'h00: begin
               alu = -1;
               for (int i = 0; i < 7; i++) if (fn_tab[i] == fn) alu = alu_tab[i];
               if (alu < 0) push(rb(), rb(), o(0, 1, 0, 0) | ILL, "exec_illegal");
               else begin
                  push(rb(), rb(), o(alu, 1, 0, 0), "exec_r");
                  push(rb(), rb(), RW | RD, "aluwb");
               end
            end
            6'h23: begin
               push(rb(), rb(), o(2, 1, 2, 0), "memadr_lw");
               wait_phase(MR | IORD, MR | IORD, wm, "memrd", ab);
               if (!ab) push(rb(), rb(), RW | M2R, "memwb");
            end
            6'h2B: begin
               push(rb(), rb(), o(2, 1, 2, 0), "memadr_sw");
               wait_phase(MW | IORD, MW | IORD, wm, "memwr", ab);
            end
            6'h04: begin
               z = zb < 0 ? rb() : zb[0];
               push(rb(), z, o(6, 1, 0, 1) | (z ? PE : 19'h0), "branch");
            end
            6'h08: begin
               push(rb(), rb(), o(2, 1, 2, 0), "addi_ex");
               push(rb(), rb(), RW, "addi_wb");
            end
            6'h02: push(rb(), rb(), o(0, 0, 0, 2) | PE, "jump");
            default: ;
         endcase
      end
      run_q(1 << 30);
   endtask
   function automatic int dw();
      return $urandom_range(0, 9) == 0 ? 16 : int'($urandom_range(0, 3));
   endfunction
   initial begin
      int ops [7] = '{0, 'h23, 'h2B, 4, 8, 2, -1};
      int k;
      logic [5:0] op, fn;
      @(negedge clk);
      #1 check("reset_state", 19'h0);
      reset = 1'b0;
      push(1'b1, 1'b0, 19'h0, "idle");
      run_q(1 << 30);
      ins(6'h00, 6'h20, 0, 0, -1);
      ins(6'h23, 6'h00, 0, 3, -1);
      ins(6'h04, 6'h00, 0, 0, 1);
      ins(6'h04, 6'h00, 0, 0, 0);
      ins(6'h3F, 6'h00, 0, 0, -1);
      ins(6'h00, 6'h3F, 0, 0, -1);
      ins(6'h00, 6'h20, 16, 0, -1);
      ins(6'h2B, 6'h00, 0, 16, -1);
      ins(6'h08, 6'h00, 1, 0, -1);
      ins(6'h02, 6'h00, 0, 0, -1);
      for (int n = 0; n < 300; n++) begin
         k = ops[$urandom_range(0, 6)];
         op = k < 0 ? 6'($urandom_range(0, 63)) : 6'(k);
         fn = rb() ? fn_tab[$urandom_range(0, 6)] : 6'($urandom_range(0, 63));
         ins(op, fn, dw(), dw(), -1);
      end
      opcode = 6'h2B;
      funct = 6'h00;
      push(1'b1, 1'b0, o(2, 0, 1, 0) | MR | IRW | PE, "fetch_sw");
      push(1'b0, 1'b0, o(2, 0, 3, 0), "decode_sw");
      push(1'b0, 1'b0, o(2, 1, 2, 0), "memadr_sw");
      push(1'b0, 1'b0, MW | IORD, "memwr_stall");
      push(1'b0, 1'b0, MW | IORD, "memwr_stall");
      run_q(1 << 30);
      mem_ready = 1'b0;
      #1 check("memwr_before_reset", MW | IORD);
      #2 reset = 1'b1;
      #1 check("reset_async_mid_memwr", 19'h0);
      @(negedge clk);
      #1 check("reset_held", 19'h0);
      reset = 1'b0;
      push(1'b1, 1'b0, 19'h0, "idle_after_reset");
      push(1'b1, 1'b0, o(2, 0, 1, 0) | MR | IRW | PE, "fetch_after_reset");
      run_q(1 << 30);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errs);
      $finish;
   end
endmodule
